// File: rtl/dfdd_pkg.sv
// Shared constants and types for the fp16 upsampler datapath.
package dfdd_pkg;

  localparam int unsigned EXP_WIDTH  = 5;
  localparam int unsigned FRAC_WIDTH = 10;
  localparam int unsigned FP16_WIDTH = 1 + EXP_WIDTH + FRAC_WIDTH;

  localparam logic [FP16_WIDTH-1:0] FP_ZERO = '0;

  typedef enum logic {
    PASS,
    ZERO
  } zi_state_t;

endpackage

// File: rtl/zero_inserter_v_2_fp16.sv
// Vertical 2x zero inserter: input row N -> output row 2N, then an all-zero row 2N+1.
// Upstream is stalled through ready_o while the zero row is produced.
module zero_inserter_v_2_fp16 #(
  parameter int unsigned EXP_WIDTH    = dfdd_pkg::EXP_WIDTH,
  parameter int unsigned FRAC_WIDTH   = dfdd_pkg::FRAC_WIDTH,
  parameter int unsigned IMG_WIDTH    = 640,
  localparam int unsigned FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [FP_WIDTH_REG-1:0] data_i,
  input  logic [15:0]             col_i,
  input  logic [15:0]             row_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic [FP_WIDTH_REG-1:0] data_o,
  output logic [15:0]             col_o,
  output logic [15:0]             row_o,
  output logic                    valid_o
);

  import dfdd_pkg::*;

  localparam logic [15:0] LAST_COL = 16'(IMG_WIDTH - 1);

  zi_state_t               state_q;
  logic [15:0]             zcnt_q;
  logic [15:0]             srow_q;
  logic [FP_WIDTH_REG-1:0] data_q;
  logic [15:0]             col_q;
  logic [15:0]             row_q;
  logic                    valid_q;

  assign ready_o = (state_q == PASS);
  assign data_o  = data_q;
  assign col_o   = col_q;
  assign row_o   = row_q;
  assign valid_o = valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= PASS;
      zcnt_q  <= '0;
      srow_q  <= '0;
      data_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        PASS: begin
          if (valid_i) begin
            data_q  <= data_i;
            col_q   <= col_i;
            // Row doubling deliberately truncates to 16 bits (row_i >= 32768 wraps).
            row_q   <= {row_i[14:0], 1'b0};
            valid_q <= 1'b1;
            if (col_i == LAST_COL) begin
              srow_q  <= row_i;
              zcnt_q  <= '0;
              state_q <= ZERO;
            end
          end else begin
            valid_q <= 1'b0;
          end
        end
        ZERO: begin
          data_q  <= FP_WIDTH_REG'(FP_ZERO);
          col_q   <= zcnt_q;
          row_q   <= {srow_q[14:0], 1'b1};
          valid_q <= 1'b1;
          zcnt_q  <= zcnt_q + 16'd1;
          if (zcnt_q == LAST_COL) begin
            state_q <= PASS;
          end
        end
        default: begin
          state_q <= PASS;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zero_inserter_v_2_fp16.sv
// Self-checking bench: two instances (IMG_WIDTH=4 and IMG_WIDTH=1) checked every cycle
// against a row-level behavioural model, plus hand-computed literal pins.
module tb_zero_inserter_v_2_fp16;

  localparam int unsigned NU = 2;

  logic        clk;
  logic        rst;
  logic [15:0] d_i   [NU];
  logic [15:0] c_i   [NU];
  logic [15:0] r_i   [NU];
  logic        v_i   [NU];
  logic        rdy_o [NU];
  logic [15:0] d_o   [NU];
  logic [15:0] c_o   [NU];
  logic [15:0] r_o   [NU];
  logic        v_o   [NU];

  int n_cmp = 0;
  int n_bad = 0;
  int nv0   = 0;
  int nr0   = 0;

  int          mw    [NU];
  int          zrem  [NU];
  int          zrow  [NU];
  logic [15:0] e_d   [NU];
  logic [15:0] e_c   [NU];
  logic [15:0] e_r   [NU];
  logic        e_v   [NU];

  zero_inserter_v_2_fp16 #(.IMG_WIDTH(4)) dut4 (
    .clk_i(clk), .rst_i(rst),
    .data_i(d_i[0]), .col_i(c_i[0]), .row_i(r_i[0]), .valid_i(v_i[0]),
    .ready_o(rdy_o[0]),
    .data_o(d_o[0]), .col_o(c_o[0]), .row_o(r_o[0]), .valid_o(v_o[0])
  );

  zero_inserter_v_2_fp16 #(.IMG_WIDTH(1)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .data_i(d_i[1]), .col_i(c_i[1]), .row_i(r_i[1]), .valid_i(v_i[1]),
    .ready_o(rdy_o[1]),
    .data_o(d_o[1]), .col_o(c_o[1]), .row_o(r_o[1]), .valid_o(v_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a pending zero row is a count of zero pixels still owed for a saved row.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int u = 0; u < NU; u++) begin
        zrem[u] = 0; zrow[u] = 0;
        e_d[u] = '0; e_c[u] = '0; e_r[u] = '0; e_v[u] = 1'b0;
      end
    end else begin
      for (int u = 0; u < NU; u++) begin
        if (zrem[u] > 0) begin
          e_d[u] = 16'h0000;
          e_c[u] = 16'(mw[u] - zrem[u]);
          e_r[u] = 16'(zrow[u] * 2 + 1);
          e_v[u] = 1'b1;
          zrem[u]--;
        end else if (v_i[u]) begin
          e_d[u] = d_i[u];
          e_c[u] = c_i[u];
          e_r[u] = 16'(int'(r_i[u]) * 2);
          e_v[u] = 1'b1;
          if (int'(c_i[u]) == mw[u] - 1) begin
            zrem[u] = mw[u];
            zrow[u] = int'(r_i[u]);
          end
        end else begin
          e_v[u] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int u = 0; u < NU; u++) begin
        check($sformatf("u%0d valid_o", u), 32'(v_o[u]), 32'(e_v[u]));
        check($sformatf("u%0d ready_o", u), 32'(rdy_o[u]), 32'(zrem[u] == 0));
        check($sformatf("u%0d data_o", u), 32'(d_o[u]), 32'(e_d[u]));
        check($sformatf("u%0d col_o", u), 32'(c_o[u]), 32'(e_c[u]));
        check($sformatf("u%0d row_o", u), 32'(r_o[u]), 32'(e_r[u]));
      end
      if (v_o[0]) nv0++;
      if (!rdy_o[0]) nr0++;
    end
  end

  // Present one pixel and return #1 after the edge that accepts it.
  task automatic send(input int u, input logic [15:0] r, input logic [15:0] c, input logic [15:0] d);
    int t;
    t = 0;
    @(negedge clk);
    d_i[u] = d; c_i[u] = c; r_i[u] = r; v_i[u] = 1'b1;
    while (!rdy_o[u] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check($sformatf("u%0d accept timeout", u), 32'(rdy_o[u]), 32'd1);
    @(posedge clk);
    #1;
    v_i[u] = 1'b0;
  endtask

  task automatic idle(input int u, input int n);
    @(negedge clk);
    v_i[u] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  logic [15:0] pix [4];
  int v_s, r_s;

  initial begin
    mw[0] = 4; mw[1] = 1;
    pix[0] = 16'h3C00; pix[1] = 16'h4000; pix[2] = 16'h4200; pix[3] = 16'h4400;
    rst = 1'b1;
    for (int u = 0; u < NU; u++) begin
      d_i[u] = '0; c_i[u] = '0; r_i[u] = '0; v_i[u] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int u = 0; u < NU; u++) begin
      check("idle valid_o", 32'(v_o[u]), 32'd0);
      check("idle ready_o", 32'(rdy_o[u]), 32'd1);
      check("idle data_o", 32'(d_o[u]), 32'd0);
      check("idle col_o", 32'(c_o[u]), 32'd0);
      check("idle row_o", 32'(r_o[u]), 32'd0);
    end

    // One row of four pixels, row 3.
    v_s = nv0; r_s = nr0;
    for (int c = 0; c < 4; c++) begin
      send(0, 16'd3, 16'(c), pix[c]);
      if (c == 0) begin
        check("A first data", 32'(d_o[0]), 32'h3C00);
        check("A first row", 32'(r_o[0]), 32'd6);
        check("A first valid", 32'(v_o[0]), 32'd1);
      end
    end
    @(posedge clk); #1;
    check("A zero0 row", 32'(r_o[0]), 32'd7);
    check("A zero0 data", 32'(d_o[0]), 32'h0000);
    idle(0, 6);
    check("A valid count", 32'(nv0 - v_s), 32'd8);
    check("A not-ready count", 32'(nr0 - r_s), 32'd4);

    // Two rows back to back.
    v_s = nv0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++)
        send(0, 16'(r), 16'(c), 16'(16'h1000 + r * 16 + c));
    idle(0, 6);
    check("B valid count", 32'(nv0 - v_s), 32'd16);

    // Gapped input within a row.
    v_s = nv0;
    for (int c = 0; c < 4; c++) begin
      send(0, 16'd2, 16'(c), 16'(16'h2000 + c));
      idle(0, 1);
    end
    idle(0, 6);
    check("C valid count", 32'(nv0 - v_s), 32'd8);

    // Reset during the second zero pixel.
    for (int c = 0; c < 4; c++) send(0, 16'd4, 16'(c), pix[c]);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("D zero1 col", 32'(c_o[0]), 32'd1);
    check("D zero1 row", 32'(r_o[0]), 32'd9);
    #1;
    rst = 1'b1;
    #1;
    check("D rst valid_o", 32'(v_o[0]), 32'd0);
    check("D rst col_o", 32'(c_o[0]), 32'd0);
    check("D rst row_o", 32'(r_o[0]), 32'd0);
    check("D rst ready_o", 32'(rdy_o[0]), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      send(0, 16'd5, 16'(c), pix[c]);
      if (c == 0) check("D row10", 32'(r_o[0]), 32'd10);
    end
    idle(0, 6);

    // IMG_WIDTH=1: row doubling at the wrap boundary.
    send(1, 16'd32767, 16'd0, 16'h1234);
    check("E data", 32'(d_o[1]), 32'h1234);
    check("E row even", 32'(r_o[1]), 32'hFFFE);
    @(posedge clk); #1;
    check("E row odd", 32'(r_o[1]), 32'hFFFF);
    check("E zero data", 32'(d_o[1]), 32'h0000);
    check("E zero valid", 32'(v_o[1]), 32'd1);
    send(1, 16'd32768, 16'd0, 16'h5678);
    check("E wrap even", 32'(r_o[1]), 32'h0000);
    @(posedge clk); #1;
    check("E wrap odd", 32'(r_o[1]), 32'h0001);
    for (int k = 0; k < 4; k++) send(1, 16'(k + 10), 16'd0, 16'(16'h3000 + k));
    idle(1, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
